// File: rtl/muldiv_hilo_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO double-write port.
// A started op takes DATA_WIDTH CALC steps. WRITE then waits for a cycle in which the
// normal WB port is idle and writes {HI,LO} in that cycle.
module muldiv_hilo_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [DATA_WIDTH-1:0]     src_a,
    input  logic [DATA_WIDTH-1:0]     src_b,
    input  logic                      cancel,
    input  logic                      wb_wen,
    output logic                      busy,
    output logic                      double_wen,
    output logic [2*DATA_WIDTH-1:0]   double_wdata
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned RW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 is_div;
    logic                 neg_q;      // negate product (mult) or quotient (div)
    logic                 neg_r;      // negate remainder (div only)
    logic                 div_zero;
    logic [DW-1:0]        a_raw;      // original dividend, returned as HI on divide by zero
    logic [DW-1:0]        opnd;       // multiplicand magnitude or divisor magnitude
    logic [DW-1:0]        hi;         // product high half / partial remainder
    logic [DW-1:0]        lo;         // multiplier shifting out / dividend->quotient

    // Operand sign handling at issue
    logic          sgn_op;
    logic          a_neg;
    logic          b_neg;
    logic [DW-1:0] a_mag;
    logic [DW-1:0] b_mag;

    always_comb begin
        sgn_op = ~op[0];
        a_neg  = sgn_op & src_a[DW-1];
        b_neg  = sgn_op & src_b[DW-1];
        a_mag  = a_neg ? DW'(-src_a) : src_a;
        b_mag  = b_neg ? DW'(-src_b) : src_b;
    end

    // One shift-add or restoring-divide step
    logic [DW:0]   mul_sum;
    logic [DW:0]   rem_sh;
    logic [DW:0]   trial;
    logic [DW-1:0] hi_nx;
    logic [DW-1:0] lo_nx;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(DW+1){1'b0}});
        rem_sh  = {hi, lo[DW-1]};
        trial   = rem_sh - {1'b0, opnd};
        hi_nx   = mul_sum[DW:1];
        lo_nx   = {mul_sum[0], lo[DW-1:1]};
        if (is_div) begin
            if (!trial[DW]) begin
                hi_nx = trial[DW-1:0];
                lo_nx = {lo[DW-2:0], 1'b1};
            end else begin
                hi_nx = rem_sh[DW-1:0];
                lo_nx = {lo[DW-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and divide-by-zero override applied on the final step
    logic [RW-1:0] fin;
    logic [DW-1:0] q_fix;
    logic [DW-1:0] r_fix;

    always_comb begin
        q_fix = neg_q ? DW'(-lo_nx) : lo_nx;
        r_fix = neg_r ? DW'(-hi_nx) : hi_nx;
        fin   = {hi_nx, lo_nx};
        if (is_div) begin
            if (div_zero) begin
                fin = {a_raw, {DW{1'b1}}};
            end else begin
                fin = {r_fix, q_fix};
            end
        end else if (neg_q) begin
            fin = RW'(-{hi_nx, lo_nx});
        end
    end

    // Strobe only when WB port is idle and the op is not being flushed
    assign double_wen = (state == S_WRITE) && !wb_wen && !cancel;

    // Sequencer state, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            double_wdata <= '0;
            is_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
            a_raw        <= '0;
            opnd         <= '0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        state    <= S_CALC;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= (src_b == '0);
                        a_raw    <= src_a;
                        hi       <= '0;
                        opnd     <= op[1] ? b_mag : a_mag;
                        lo       <= op[1] ? a_mag : b_mag;
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        hi <= hi_nx;
                        lo <= lo_nx;
                        if (cnt == CNT_WIDTH'(DW - 1)) begin
                            state        <= S_WRITE;
                            cnt          <= '0;
                            double_wdata <= fin;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (cancel || !wb_wen) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_seq.sv
// Directed bench for muldiv_hilo_seq: results, latency, WB deferral, cancel, async reset.
module tb_muldiv_hilo_seq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        wb_wen;
    logic        busy;
    logic        double_wen;
    logic [63:0] double_wdata;

    int n_checks;
    int n_pass;

    muldiv_hilo_seq #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .cancel       (cancel),
        .wb_wen       (wb_wen),
        .busy         (busy),
        .double_wen   (double_wen),
        .double_wdata (double_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one op from IDLE and follow it through to the write and back to IDLE
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int hold,
                          input bit poke);
        logic early;
        early = 1'b0;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; src_a = 32'hA5A5_5A5A; src_b = 32'h0000_0003;
        check({tag, " busy_on"}, 64'(busy), 64'd1);
        for (int k = 1; k <= 31; k++) begin
            if (poke && k == 5) begin start = 1'b1; op = 2'b01; end
            if (poke && k == 6) start = 1'b0;
            @(posedge clk); #1;
            if (double_wen || !busy) early = 1'b1;
        end
        wb_wen = (hold > 0);
        @(posedge clk); #1;
        check({tag, " no_early_wen"}, 64'(early), 64'd0);
        for (int j = 0; j < hold; j++) begin
            check({tag, " wen_deferred"}, 64'(double_wen), 64'd0);
            check({tag, " busy_hold"}, 64'(busy), 64'd1);
            @(posedge clk); #1;
        end
        wb_wen = 1'b0;
        #1;
        check({tag, " wen"}, 64'(double_wen), 64'd1);
        check({tag, " wdata"}, double_wdata, exp);
        @(posedge clk); #1;
        check({tag, " idle_busy"}, 64'(busy), 64'd0);
        check({tag, " idle_wen"}, 64'(double_wen), 64'd0);
        check({tag, " wdata_held"}, double_wdata, exp);
    endtask

    initial begin
        logic bad;
        n_checks = 0; n_pass = 0;
        rstn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        cancel = 1'b0; wb_wen = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wen", 64'(double_wen), 64'd0);
        check("rst_wdata", double_wdata, 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b1);
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
        run_op("divu_zero", 2'b11, 32'h0000_1234, 32'h0000_0000, 64'h0000_1234_FFFF_FFFF, 0, 1'b0);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 1'b0);

        // Flush at counter 10: no write, result register untouched
        op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (double_wen || busy) bad = 1'b1;
        end
        check("cancel_quiet", 64'(bad), 64'd0);
        check("cancel_wdata", double_wdata, 64'h0000_0000_8000_0000);
        start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("start_cancel_idle", 64'(busy), 64'd0);

        run_op("mult_hold", 2'b00, 32'h1234_5678, 32'hFFFF_FFFE, 64'hFFFF_FFFF_DB97_5310, 3, 1'b0);
        run_op("div_negb",  2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 1'b0);

        // Asynchronous reset between edges in the middle of CALC
        op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_wen", 64'(double_wen), 64'd0);
        check("arst_wdata", double_wdata, 64'd0);
        #2;
        rstn = 1'b1;
        @(posedge clk); #1;
        check("arst_stay_idle", 64'(busy), 64'd0);

        run_op("divu_after_rst", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
